// File: rtl/div_pkg.sv
// Shared types and constants for the selectable-operand sequential divider.
package div_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Operand-pair encodings: first letter is the dividend, second the divisor.
  localparam logic [1:0] SEL_AB = 2'b00;
  localparam logic [1:0] SEL_BC = 2'b01;
  localparam logic [1:0] SEL_CD = 2'b10;
  localparam logic [1:0] SEL_DA = 2'b11;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor if it fits, and report the resulting quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem_c,
  output logic             q_bit_c
);

  logic [WIDTH+1:0] shifted_c;

  always_comb begin
    shifted_c  = {rem_in, dividend_bit};
    q_bit_c    = (shifted_c >= {2'b00, divisor});
    next_rem_c = q_bit_c ? (WIDTH+1)'(shifted_c - {2'b00, divisor})
                         : (WIDTH+1)'(shifted_c);
  end

endmodule

// File: rtl/seq_div_sel.sv
// Sequential unsigned restoring divider with a 4-way operand-pair selector.
// Results appear WIDTH cycles after acceptance; a zero divisor short-circuits.
module seq_div_sel
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       select,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             error
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   prem_q;

  logic [WIDTH-1:0] dividend_c;
  logic [WIDTH-1:0] divisor_c;
  logic [WIDTH:0]   step_rem_c;
  logic             step_q_c;

  // Operand-pair selection
  always_comb begin
    dividend_c = A;
    divisor_c  = B;
    case (select)
      SEL_AB: begin dividend_c = A; divisor_c = B; end
      SEL_BC: begin dividend_c = B; divisor_c = C; end
      SEL_CD: begin dividend_c = C; divisor_c = D; end
      SEL_DA: begin dividend_c = D; divisor_c = A; end
      default: ;
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (prem_q),
    .dividend_bit (quo_q[WIDTH-1]),
    .divisor      (divisor_q),
    .next_rem_c   (step_rem_c),
    .q_bit_c      (step_q_c)
  );

  // Control FSM; the dividend register doubles as the quotient shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      prem_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      rem       <= '0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt <= '0;
            if (divisor_c == '0) begin
              state <= DONE;
              out   <= '0;
              rem   <= '0;
              error <= 1'b1;
              done  <= 1'b1;
            end else begin
              state     <= DIV;
              busy      <= 1'b1;
              divisor_q <= divisor_c;
              quo_q     <= dividend_c;
              prem_q    <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        DIV: begin
          prem_q <= step_rem_c;
          quo_q  <= {quo_q[WIDTH-2:0], step_q_c};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            out   <= {quo_q[WIDTH-2:0], step_q_c};
            rem   <= step_rem_c[WIDTH-1:0];
            error <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
